// File: rtl/sort16_frame_ctrl_if.sv
// Sample-stream and result-stream handshake bundle for the sort16 frame sequencer.
// slave: the sequencer side (consumes samples, produces results).
// master: the surrounding source/consumer side.
interface sort16_frame_ctrl_if #(
  parameter int W = 12
) ();
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W+3:0] m_sum;
  logic [W-1:0] m_max;
  logic         m_short;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_sum, m_max, m_short
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_sum, m_max, m_short
  );
endinterface

// File: rtl/sort16_frame_ctrl.sv
// Frame sequencer for the top-16 keep-max sorter: clears the sorter, feeds it one
// frame of samples, waits for the sorter pipeline, then hands out sum/max.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_CLEAR  | sorter held in clear for one cycle, frame length latched
//  ST_FILL   | samples accepted and forwarded to the sorter
//  ST_SETTLE | waiting SORT_LAT cycles for sorter sum/max to become valid
//  ST_OUT    | result presented, held until the consumer takes it
module sort16_frame_ctrl #(
  parameter int W        = 12,
  parameter int LW       = 16,
  parameter int SORT_LAT = 2
) (
  input  logic                 clk,
  input  logic                 synrst,
  input  logic [LW-1:0]        cfg_len,
  input  logic                 abort,
  sort16_frame_ctrl_if.slave   bus,
  output logic                 srt_clr,
  output logic                 srt_en,
  output logic [W-1:0]         srt_data,
  input  logic [W+3:0]         srt_sum,
  input  logic [W-1:0]         srt_max,
  output logic [15:0]          frame_cnt
);

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  localparam int              WAW       = (SORT_LAT < 2) ? 1 : $clog2(SORT_LAT + 1);
  localparam logic [WAW-1:0]  WAIT_INIT = WAW'(SORT_LAT);

  logic [1:0]     state;
  logic [LW-1:0]  len;
  logic [LW-1:0]  cnt;
  logic [WAW-1:0] wait_cnt;
  logic           fill;
  logic           accept;

  // Handshake and sorter drive are pure decodes of the registered state, so
  // s_ready drops the cycle after the last accept and clr/en can never overlap.
  always_comb begin
    fill        = (state == ST_FILL);
    accept      = bus.s_valid & fill;
    bus.s_ready = fill;
    srt_en      = accept;
    srt_clr     = (state == ST_CLEAR) | synrst;
    srt_data    = bus.s_data;
  end

  // Frame sequencing, sample counting, settle timer and result capture.
  always_ff @(posedge clk or posedge synrst) begin
    if (synrst) begin
      state       <= ST_CLEAR;
      len         <= LW'(1);
      cnt         <= '0;
      wait_cnt    <= '0;
      bus.m_valid <= 1'b0;
      bus.m_sum   <= '0;
      bus.m_max   <= '0;
      bus.m_short <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          // A zero length would never terminate the frame, so it runs as one sample.
          len   <= (cfg_len == '0) ? LW'(1) : cfg_len;
          cnt   <= '0;
          state <= ST_FILL;
        end
        ST_FILL: begin
          if (abort) begin
            state <= ST_CLEAR;
          end else if (accept) begin
            cnt <= cnt + LW'(1);
            if (cnt == len - LW'(1)) begin
              state    <= ST_SETTLE;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_CLEAR;
          end else if (wait_cnt == WAW'(1)) begin
            bus.m_sum   <= srt_sum;
            bus.m_max   <= srt_max;
            bus.m_short <= (len < LW'(16));
            bus.m_valid <= 1'b1;
            state       <= ST_OUT;
          end else begin
            wait_cnt <= wait_cnt - WAW'(1);
          end
        end
        ST_OUT: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            frame_cnt   <= frame_cnt + 16'd1;
            state       <= ST_CLEAR;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule
